// File: rtl/serial_rx_byte_if.sv
// Output bus of the serial frame receiver: received word plus valid/ready handshake.
//   dout       - received word, stable while dout_valid is high
//   dout_valid - holding buffer full
//   dout_ready - consumer accepts dout when dout_valid && dout_ready at a clock edge
// The receiver drives the master side; the consumer uses the slave side.
interface serial_rx_byte_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;

  modport master (
    output dout,
    output dout_valid,
    input  dout_ready
  );

  modport slave (
    input  dout,
    input  dout_valid,
    output dout_ready
  );
endinterface

// File: rtl/serial_rx_byte.sv
// Serial-to-parallel frame receiver. Samples the line once per bit_en_i strobe, finds a
// start bit, assembles WIDTH data bits, checks an optional parity bit and the stop bit,
// and hands the word out through a one-entry valid/ready holding buffer.
//   clk, rst      - clock, synchronous active-high reset
//   sin_i         - serial line, idle high
//   bit_en_i      - bit strobe; the line is sampled only when high
//   out_if        - word output with valid/ready handshake (master side)
//   busy_o        - receiver is not idle
//   frame_err_o   - one-cycle pulse: stop bit sampled low
//   parity_err_o  - one-cycle pulse: parity mismatch, word dropped
//   overrun_o     - one-cycle pulse: good word dropped because the buffer was full
module serial_rx_byte #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b0,
  parameter bit          PARITY_EN  = 1'b1,
  parameter bit          ODD_PARITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sin_i,
  input  logic              bit_en_i,
  serial_rx_byte_if.master  out_if,
  output logic              busy_o,
  output logic              frame_err_o,
  output logic              parity_err_o,
  output logic              overrun_o
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StData,
    StParity,
    StStop,
    StWaitIdle
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             par_q, par_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             fe_q, fe_d;
  logic             pe_q, pe_d;
  logic             ov_q, ov_d;

  logic             word_done;
  logic             par_bad;
  logic             load;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the FSM only advances on strobe cycles
  always_comb begin
    state_d = state_q;
    if (bit_en_i) begin
      unique case (state_q)
        StIdle: begin
          if (!sin_i) state_d = StData;
        end
        StData: begin
          if (cnt_q == LastCnt) begin
            if (PARITY_EN) state_d = StParity;
            else           state_d = StStop;
          end
        end
        StParity: state_d = StStop;
        StStop: begin
          if (sin_i) state_d = StIdle;
          else       state_d = StWaitIdle;
        end
        // Line break: wait for the line to return high before hunting a new start bit
        StWaitIdle: begin
          if (sin_i) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Output logic
  always_comb begin
    busy_o            = (state_q != StIdle);
    out_if.dout       = dout_q;
    out_if.dout_valid = valid_q;
    frame_err_o       = fe_q;
    parity_err_o      = pe_q;
    overrun_o         = ov_q;
  end

  // Datapath next-state: counter, shift register, holding buffer and pulse flags
  always_comb begin
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    fe_d    = 1'b0;
    pe_d    = 1'b0;
    ov_d    = 1'b0;
    load    = 1'b0;

    word_done = bit_en_i && (state_q == StStop) && sin_i;
    par_bad   = PARITY_EN && (par_q != ((^shreg_q) ^ ODD_PARITY));

    if (bit_en_i) begin
      if (state_q == StIdle && !sin_i) begin
        cnt_d = '0;
      end
      if (state_q == StData) begin
        cnt_d = cnt_q + CntW'(1);
        if (MSB_FIRST) shreg_d = {shreg_q[WIDTH-2:0], sin_i};
        else           shreg_d = {sin_i, shreg_q[WIDTH-1:1]};
      end
      if (state_q == StParity) begin
        par_d = sin_i;
      end
      // Stop-bit error outranks parity, so only frame_err fires here
      if (state_q == StStop && !sin_i) begin
        fe_d = 1'b1;
      end
    end

    if (word_done) begin
      if (par_bad) begin
        pe_d = 1'b1;
      end else if (!valid_q || out_if.dout_ready) begin
        load = 1'b1;
      end else begin
        ov_d = 1'b1;
      end
    end

    // A load on the consuming edge keeps valid high with the new word
    if (load) begin
      dout_d  = shreg_q;
      valid_d = 1'b1;
    end else if (valid_q && out_if.dout_ready) begin
      valid_d = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      pe_q    <= pe_d;
      ov_q    <= ov_d;
    end
  end

endmodule

// File: tb/tb_serial_rx_byte.sv
// Self-checking bench for serial_rx_byte (WIDTH=8, LSB first, even parity). Frames are
// built from their bit-level description; the expected outcome of each frame and the
// holding-buffer contents are tracked by a small behavioural model and compared every cycle.
module tb_serial_rx_byte;

  localparam int EvNone = 0;
  localparam int EvOk   = 1;
  localparam int EvPe   = 2;
  localparam int EvFe   = 3;

  logic clk = 1'b0;
  logic rst;
  logic sin_i;
  logic bit_en_i;
  logic busy_o;
  logic frame_err_o;
  logic parity_err_o;
  logic overrun_o;

  serial_rx_byte_if #(.WIDTH(8)) rx_if ();

  serial_rx_byte #(
    .WIDTH      (8),
    .MSB_FIRST  (1'b0),
    .PARITY_EN  (1'b1),
    .ODD_PARITY (1'b0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sin_i        (sin_i),
    .bit_en_i     (bit_en_i),
    .out_if       (rx_if),
    .busy_o       (busy_o),
    .frame_err_o  (frame_err_o),
    .parity_err_o (parity_err_o),
    .overrun_o    (overrun_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic       exp_valid = 1'b0;
  logic [7:0] exp_dout  = 8'h00;
  logic       exp_busy  = 1'b0;
  logic       exp_fe, exp_pe, exp_ov;
  bit         rand_ready = 1'b0;
  int         stop_ready = -1;
  int         n_delivered = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic cyc(input logic s, input logic en, input logic nb, input int ev,
                     input logic [7:0] w);
    logic load;
    sin_i    = s;
    bit_en_i = en;
    if (rand_ready) rx_if.dout_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    exp_fe = 1'b0;
    exp_pe = 1'b0;
    exp_ov = 1'b0;
    load   = 1'b0;
    if (rst) begin
      exp_valid = 1'b0;
      exp_dout  = 8'h00;
      exp_busy  = 1'b0;
    end else begin
      exp_busy = nb;
      if (en) begin
        case (ev)
          EvFe: exp_fe = 1'b1;
          EvPe: exp_pe = 1'b1;
          EvOk: begin
            if (!exp_valid || rx_if.dout_ready) load = 1'b1;
            else                                exp_ov = 1'b1;
          end
          default: ;
        endcase
      end
      if (load) begin
        exp_valid = 1'b1;
        exp_dout  = w;
        n_delivered++;
      end else if (exp_valid && rx_if.dout_ready) begin
        exp_valid = 1'b0;
      end
    end
    #1;
    check_eq("dout_valid", 32'(rx_if.dout_valid), 32'(exp_valid));
    check_eq("dout",       32'(rx_if.dout),       32'(exp_dout));
    check_eq("busy",       32'(busy_o),           32'(exp_busy));
    check_eq("frame_err",  32'(frame_err_o),      32'(exp_fe));
    check_eq("parity_err", 32'(parity_err_o),     32'(exp_pe));
    check_eq("overrun",    32'(overrun_o),        32'(exp_ov));
  endtask

  // One line bit, with (period-1) non-strobe cycles of line noise before the strobe
  task automatic send_bit(input logic b, input logic nb, input int ev, input logic [7:0] w,
                          input int period);
    for (int i = 0; i < period - 1; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'b0, exp_busy, EvNone, 8'h00);
    end
    cyc(b, 1'b1, nb, ev, w);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par_ok, input logic stop_ok,
                            input int period);
    logic pbit;
    int   ev;
    pbit = (^data) ^ !par_ok;
    send_bit(1'b0, 1'b1, EvNone, 8'h00, period);
    for (int i = 0; i < 8; i++) send_bit(data[i], 1'b1, EvNone, 8'h00, period);
    send_bit(pbit, 1'b1, EvNone, 8'h00, period);
    if (stop_ready >= 0) rx_if.dout_ready = stop_ready[0];
    if (!stop_ok)     ev = EvFe;
    else if (!par_ok) ev = EvPe;
    else              ev = EvOk;
    send_bit(stop_ok, !stop_ok, ev, data, period);
    stop_ready = -1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b0, EvNone, 8'h00);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, EvNone, 8'h00);
    cyc(1'b1, 1'b1, 1'b0, EvNone, 8'h00);
    rst = 1'b0;
  endtask

  initial begin
    rst              = 1'b1;
    sin_i            = 1'b1;
    bit_en_i         = 1'b0;
    rx_if.dout_ready = 1'b1;
    do_reset();
    idle(2);

    // 1: basic frame
    send_frame(8'hA5, 1'b1, 1'b1, 1);
    check_eq("t1_dout", 32'(rx_if.dout), 32'h0000_00A5);
    idle(2);

    // 2: parity mismatch drops the word
    send_frame(8'h01, 1'b0, 1'b1, 1);
    idle(2);

    // 3: stop error, line break, then a good frame
    send_frame(8'h3C, 1'b1, 1'b0, 1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1, EvNone, 8'h00);
    idle(2);
    send_frame(8'h11, 1'b1, 1'b1, 1);
    check_eq("t3_dout", 32'(rx_if.dout), 32'h0000_0011);
    idle(2);

    // 4: overrun with consumer stalled, then a load on the consuming edge
    rx_if.dout_ready = 1'b0;
    send_frame(8'h12, 1'b1, 1'b1, 1);
    idle(1);
    send_frame(8'h34, 1'b1, 1'b1, 1);
    check_eq("t4_held", 32'(rx_if.dout), 32'h0000_0012);
    idle(1);
    stop_ready = 1;
    send_frame(8'h34, 1'b1, 1'b1, 1);
    check_eq("t4_swap", 32'(rx_if.dout), 32'h0000_0034);
    rx_if.dout_ready = 1'b1;
    idle(2);

    // 5: strobe every 4th cycle
    send_frame(8'hC3, 1'b1, 1'b1, 4);
    idle(2);

    // 6: reset mid-frame
    cyc(1'b0, 1'b1, 1'b1, EvNone, 8'h00);
    for (int i = 0; i < 4; i++) cyc(1'($urandom_range(0, 1)), 1'b1, 1'b1, EvNone, 8'h00);
    do_reset();
    idle(2);
    send_frame(8'h5A, 1'b1, 1'b1, 1);
    check_eq("t6_dout", 32'(rx_if.dout), 32'h0000_005A);
    idle(2);

    // Randomized frames, strobe spacing and consumer back-pressure
    rand_ready = 1'b1;
    for (int f = 0; f < 60; f++) begin
      logic [7:0] d;
      logic       pok, sok;
      d   = 8'($urandom_range(0, 255));
      pok = ($urandom_range(0, 4) != 0);
      sok = ($urandom_range(0, 5) != 0);
      send_frame(d, pok, sok, int'($urandom_range(1, 4)));
      if (!sok) begin
        for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
          cyc(1'b0, 1'b1, 1'b1, EvNone, 8'h00);
        end
      end
      idle(int'($urandom_range(1, 3)));
    end
    rand_ready = 1'b0;
    rx_if.dout_ready = 1'b1;
    idle(3);
    check_eq("delivered_any", 32'(n_delivered > 5), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
